// File: rtl/alu_cmd_sequencer_if.sv
// Signal bundle between alu_cmd_sequencer and its environment: the command
// channel, the response channel, the ALU operand/result wires and the
// architectural flag register. Optional feature macro: ALU_SEQ_STICKY_OVF_EN
// adds StickyV / ClearSticky.
//
// Handshake rule for both channels: a transfer happens at a rising clk edge
// where valid && ready are both 1. The source holds its payload stable while
// valid is high and ready is low, and valid never depends combinationally on
// ready.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             CmdValid;
  logic             CmdReady;
  logic [WIDTH-1:0] CmdA;
  logic [WIDTH-1:0] CmdB;
  logic [1:0]       CmdOp;
  logic [3:0]       CmdCond;
  logic [1:0]       CmdFlagWrite;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       ALUControl;
  logic [WIDTH-1:0] Result;
  logic [3:0]       ALUFlags;
  logic             RspValid;
  logic             RspReady;
  logic [WIDTH-1:0] RspResult;
  logic [3:0]       RspFlags;
  logic             RspExec;
  logic [3:0]       Flags;
`ifdef ALU_SEQ_STICKY_OVF_EN
  logic             StickyV;
  logic             ClearSticky;

  modport master (
    input  CmdValid, CmdA, CmdB, CmdOp, CmdCond, CmdFlagWrite,
    input  Result, ALUFlags, RspReady, ClearSticky,
    output CmdReady, A, B, ALUControl,
    output RspValid, RspResult, RspFlags, RspExec, Flags, StickyV
  );

  modport slave (
    output CmdValid, CmdA, CmdB, CmdOp, CmdCond, CmdFlagWrite,
    output Result, ALUFlags, RspReady, ClearSticky,
    input  CmdReady, A, B, ALUControl,
    input  RspValid, RspResult, RspFlags, RspExec, Flags, StickyV
  );
`else
  modport master (
    input  CmdValid, CmdA, CmdB, CmdOp, CmdCond, CmdFlagWrite,
    input  Result, ALUFlags, RspReady,
    output CmdReady, A, B, ALUControl,
    output RspValid, RspResult, RspFlags, RspExec, Flags
  );

  modport slave (
    output CmdValid, CmdA, CmdB, CmdOp, CmdCond, CmdFlagWrite,
    output Result, ALUFlags, RspReady,
    input  CmdReady, A, B, ALUControl,
    input  RspValid, RspResult, RspFlags, RspExec, Flags
  );
`endif
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequential front end for a combinational ALU. Accepts one command, drives
// the ALU from registers for one settle cycle, captures Result/ALUFlags,
// conditionally updates the NZCV register and returns the result.
// Optional feature macro: ALU_SEQ_STICKY_OVF_EN (sticky overflow bit).
// state_dbg exposes the FSM state: 0 IDLE, 1 EXEC, 2 RESP.
module alu_cmd_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_cmd_sequencer_if.master bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cond_q;
  logic [1:0] fw_q;
  logic       cond_ex;
  logic       accept;

  // ARM condition evaluation against flags {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = cf;
      4'b0011: cond_pass = !cf;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = cf && !z;
      4'b1001: cond_pass = !cf || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Ready in IDLE, or in RESP when the response is leaving on this edge.
  assign bus.CmdReady = (state == IDLE) || ((state == RESP) && bus.RspReady);
  assign accept       = bus.CmdValid && bus.CmdReady;
  assign cond_ex      = cond_pass(cond_q, bus.Flags);
  assign state_dbg    = state;

  // Control FSM with registered ALU drive, response and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      bus.A          <= '0;
      bus.B          <= '0;
      bus.ALUControl <= 2'b00;
      cond_q         <= 4'b0000;
      fw_q           <= 2'b00;
      bus.RspValid   <= 1'b0;
      bus.RspResult  <= '0;
      bus.RspFlags   <= 4'b0000;
      bus.RspExec    <= 1'b0;
      bus.Flags      <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.A          <= bus.CmdA;
            bus.B          <= bus.CmdB;
            bus.ALUControl <= bus.CmdOp;
            cond_q         <= bus.CmdCond;
            fw_q           <= bus.CmdFlagWrite;
            state          <= EXEC;
          end
        end
        EXEC: begin
          bus.RspResult <= bus.Result;
          bus.RspFlags  <= bus.ALUFlags;
          bus.RspExec   <= cond_ex;
          bus.RspValid  <= 1'b1;
          if (cond_ex && fw_q[1]) bus.Flags[3:2] <= bus.ALUFlags[3:2];
          if (cond_ex && fw_q[0]) bus.Flags[1:0] <= bus.ALUFlags[1:0];
          state <= RESP;
        end
        RESP: begin
          if (bus.RspReady) begin
            bus.RspValid <= 1'b0;
            if (accept) begin
              bus.A          <= bus.CmdA;
              bus.B          <= bus.CmdB;
              bus.ALUControl <= bus.CmdOp;
              cond_q         <= bus.CmdCond;
              fw_q           <= bus.CmdFlagWrite;
              state          <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_OVF_EN
  // Sticky overflow: set when V is written with 1; a set beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.StickyV <= 1'b0;
    end else if ((state == EXEC) && cond_ex && fw_q[0] && bus.ALUFlags[0]) begin
      bus.StickyV <= 1'b1;
    end else if (bus.ClearSticky) begin
      bus.StickyV <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: bench-side ALU, transaction-level model
// with expected queue, per-cycle compare process, directed vectors.
module tb_alu_cmd_sequencer;
  localparam int W = 4;

  logic       clk;
  logic       reset_n;
  logic [1:0] state_dbg;
  int         tests;
  int         fails;

  alu_cmd_sequencer_if #(.WIDTH(W)) bus ();

  alu_cmd_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench ALU (combinational) ----------------
  logic [W:0]   alu_sum;
  logic [W-1:0] alu_bm;
  always_comb begin
    alu_bm       = bus.ALUControl[0] ? ~bus.B : bus.B;
    alu_sum      = {1'b0, bus.A} + {1'b0, alu_bm} + {{W{1'b0}}, bus.ALUControl[0]};
    bus.Result   = '0;
    bus.ALUFlags = 4'b0000;
    case (bus.ALUControl)
      2'b00, 2'b01: begin
        bus.Result      = alu_sum[W-1:0];
        bus.ALUFlags[1] = alu_sum[W];
        bus.ALUFlags[0] = (bus.A[W-1] == alu_bm[W-1]) && (alu_sum[W-1] != bus.A[W-1]);
      end
      2'b10:   bus.Result = bus.A & bus.B;
      default: bus.Result = bus.A | bus.B;
    endcase
    bus.ALUFlags[3] = bus.Result[W-1];
    bus.ALUFlags[2] = (bus.Result == '0);
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Entry: {result[3:0], alu_flags[3:0], exec, flags_after[3:0]}
  logic [12:0] exp_q[$];
  logic [3:0]  m_flags;
  logic        exec_stage;
  logic        lat_due;

  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      0: return z;              1: return !z;
      2: return cc;             3: return !cc;
      4: return n;              5: return !n;
      6: return v;              7: return !v;
      8: return cc && !z;       9: return !cc || z;
      10: return n == v;        11: return n != v;
      12: return !z && n == v;  13: return z || n != v;
      14: return 1;             default: return 0;
    endcase
  endfunction

  function automatic logic [12:0] m_exec(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op, input logic [3:0] c,
                                         input logic [1:0] fw, input logic [3:0] f);
    int ua, ub, sa, sb, r, sr;
    logic [3:0] res, af, nf;
    logic ex;
    ua = a; ub = b;
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    af = 4'b0000;
    case (op)
      2'b00: begin
        r = ua + ub; sr = sa + sb;
        af[1] = (r >= 16); af[0] = (sr > 7) || (sr < -8);
      end
      2'b01: begin
        r = ua - ub; sr = sa - sb;
        af[1] = (ua >= ub); af[0] = (sr > 7) || (sr < -8);
      end
      2'b10: r = ua & ub;
      default: r = ua | ub;
    endcase
    res   = 4'(r & 15);
    af[3] = (res >= 8);
    af[2] = (res == 0);
    ex    = m_cond(c, f);
    nf    = f;
    if (ex && fw[1]) nf[3:2] = af[3:2];
    if (ex && fw[0]) nf[1:0] = af[1:0];
    return {res, af, ex, nf};
  endfunction

  // Monitor: records accepted commands into the expected queue.
  always @(posedge clk or negedge reset_n) begin
    logic [12:0] e;
    if (!reset_n) begin
      exp_q.delete();
      m_flags    = 4'b0000;
      exec_stage = 1'b0;
      lat_due    = 1'b0;
    end else begin
      if (bus.RspValid && bus.RspReady && exp_q.size() > 0) void'(exp_q.pop_front());
      lat_due    = exec_stage;
      exec_stage = 1'b0;
      if (bus.CmdValid && bus.CmdReady) begin
        e = m_exec(bus.CmdA, bus.CmdB, bus.CmdOp, bus.CmdCond, bus.CmdFlagWrite, m_flags);
        m_flags = e[3:0];
        exp_q.push_back(e);
        exec_stage = 1'b1;
      end
    end
  end

  // Compare process: checks outputs every cycle they are meaningful.
  always @(negedge clk) begin
    if (reset_n) begin
      if (lat_due) chk("latency_rsp_valid", 32'(bus.RspValid), 32'd1);
      if (bus.RspValid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got RspValid=1 expected no response at %0t", $time);
        end else begin
          chk("rsp_result", 32'(bus.RspResult), 32'(exp_q[0][12:9]));
          chk("rsp_flags",  32'(bus.RspFlags),  32'(exp_q[0][8:5]));
          chk("rsp_exec",   32'(bus.RspExec),   32'(exp_q[0][4]));
          chk("arch_flags", 32'(bus.Flags),     32'(exp_q[0][3:0]));
        end
        if (!bus.RspReady) chk("bp_cmd_ready", 32'(bus.CmdReady), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                      input logic [3:0] c, input logic [1:0] fw, output int waited);
    bus.CmdA = a; bus.CmdB = b; bus.CmdOp = op;
    bus.CmdCond = c; bus.CmdFlagWrite = fw;
    bus.CmdValid = 1'b1;
    waited = 0;
    #1;
    while (!bus.CmdReady && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!bus.CmdReady) begin
      tests++;
      fails++;
      $display("FAIL cmd_accept_timeout: got CmdReady=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    bus.CmdValid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!bus.RspValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.RspValid) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: got RspValid=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic do_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input logic [3:0] c, input logic [1:0] fw);
    int w;
    @(negedge clk);
    send(a, b, op, c, fw, w);
    wait_rsp();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int seen;
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    bus.CmdValid = 1'b0; bus.CmdA = '0; bus.CmdB = '0; bus.CmdOp = 2'b00;
    bus.CmdCond = 4'b0000; bus.CmdFlagWrite = 2'b00; bus.RspReady = 1'b1;
`ifdef ALU_SEQ_STICKY_OVF_EN
    bus.ClearSticky = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cmd_ready", 32'(bus.CmdReady), 32'd1);
    chk("rst_rsp_valid", 32'(bus.RspValid), 32'd0);
    chk("rst_flags", 32'(bus.Flags), 32'd0);
    chk("rst_a", 32'(bus.A), 32'd0);
    chk("rst_b", 32'(bus.B), 32'd0);
    chk("rst_alu_control", 32'(bus.ALUControl), 32'd0);
    chk("rst_rsp_result", 32'(bus.RspResult), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    reset_n = 1'b1;

    // Add with flags: 0111 + 0100
    do_cmd(4'b0111, 4'b0100, 2'b00, 4'b1110, 2'b11);
    chk("add_result", 32'(bus.RspResult), 32'b1011);
    chk("add_rsp_flags", 32'(bus.RspFlags), 32'b1001);
    chk("add_exec", 32'(bus.RspExec), 32'd1);
    chk("add_flags", 32'(bus.Flags), 32'b1001);

    // Failed condition: 0101 - 0011 with EQ
    do_cmd(4'b0101, 4'b0011, 2'b01, 4'b0000, 2'b11);
    chk("eq_fail_result", 32'(bus.RspResult), 32'b0010);
    chk("eq_fail_exec", 32'(bus.RspExec), 32'd0);
    chk("eq_fail_flags", 32'(bus.Flags), 32'b1001);

    // Partial flag write: 0010 & 0101, N,Z only
    do_cmd(4'b0010, 4'b0101, 2'b10, 4'b1110, 2'b10);
    chk("and_result", 32'(bus.RspResult), 32'b0000);
    chk("and_flags", 32'(bus.Flags), 32'b0101);
    chk("operands_held_a", 32'(bus.A), 32'b0010);

    // Backpressure: 0101 | 0010 with RspReady low for 5 cycles
    @(negedge clk);
    bus.RspReady = 1'b0;
    send(4'b0101, 4'b0010, 2'b11, 4'b1110, 2'b00, w);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      chk("bp_result_held", 32'(bus.RspResult), 32'b0111);
      chk("bp_cmd_ready_low", 32'(bus.CmdReady), 32'd0);
      @(negedge clk);
    end
    bus.RspReady = 1'b1;
    send(4'b0011, 4'b0101, 2'b01, 4'b1110, 2'b11, w);
    chk("bp_same_edge_accept", 32'(w), 32'd0);
    wait_rsp();
    chk("sub_borrow_result", 32'(bus.RspResult), 32'b1110);
    chk("sub_borrow_flags", 32'(bus.Flags), 32'b1000);

    // Further directed vectors
    do_cmd(4'b1000, 4'b0001, 2'b01, 4'b0100, 2'b11);  // MI passes, overflow
    chk("sub_ovf_flags", 32'(bus.Flags), 32'b0011);
    do_cmd(4'b0001, 4'b0001, 2'b00, 4'b1010, 2'b11);  // GE fails
    chk("ge_fail_exec", 32'(bus.RspExec), 32'd0);
    do_cmd(4'b0001, 4'b0001, 2'b00, 4'b1000, 2'b01);  // HI passes, C,V only
    chk("hi_cv_flags", 32'(bus.Flags), 32'b0000);
    do_cmd(4'b0000, 4'b0000, 2'b11, 4'b1111, 2'b11);  // never executes
    chk("nv_exec", 32'(bus.RspExec), 32'd0);

    // Walk every condition code, back to back
    for (int c = 0; c < 16; c++) do_cmd(4'(c), 4'b0101, 2'b01, 4'(c), 2'b11);

`ifdef ALU_SEQ_STICKY_OVF_EN
    @(negedge clk);
    bus.ClearSticky = 1'b1;
    @(negedge clk);
    bus.ClearSticky = 1'b0;
    chk("sticky_cleared_init", 32'(bus.StickyV), 32'd0);
    do_cmd(4'b0111, 4'b0100, 2'b00, 4'b1110, 2'b01);
    chk("sticky_set", 32'(bus.StickyV), 32'd1);
    do_cmd(4'b0001, 4'b0001, 2'b00, 4'b1110, 2'b11);
    chk("sticky_hold", 32'(bus.StickyV), 32'd1);
    @(negedge clk);
    bus.ClearSticky = 1'b1;
    @(negedge clk);
    bus.ClearSticky = 1'b0;
    chk("sticky_clear", 32'(bus.StickyV), 32'd0);
`endif

    // Reset mid-EXEC: make Flags nonzero first
    do_cmd(4'b0111, 4'b0100, 2'b00, 4'b1110, 2'b11);
    @(negedge clk);
    send(4'b1111, 4'b0001, 2'b00, 4'b1110, 2'b11, w);
    chk("pre_rst_state_exec", 32'(state_dbg), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_flags", 32'(bus.Flags), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.RspValid), 32'd0);
    chk("midrst_a", 32'(bus.A), 32'd0);
    chk("midrst_b", 32'(bus.B), 32'd0);
    chk("midrst_cmd_ready", 32'(bus.CmdReady), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.RspValid) seen++;
    end
    chk("no_rsp_after_reset", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
